// File: rtl/gat_run_ctrl_if.sv
// ============================================================================
// Module      : gat_run_ctrl_if
// Description : Core feature-write handshake and new-feature BRAM port-A bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gat_run_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 16
);
    logic                  feat_in_valid;
    logic [DATA_WIDTH-1:0] feat_in_data;
    logic                  feat_in_ready;
    logic                  feat_bram_ena;
    logic [ADDR_W-1:0]     feat_bram_addra;
    logic [DATA_WIDTH-1:0] feat_bram_din;

    // master: core side producing features and observing the BRAM port
    modport master (
        output feat_in_valid,
        output feat_in_data,
        input  feat_in_ready,
        input  feat_bram_ena,
        input  feat_bram_addra,
        input  feat_bram_din
    );

    // slave: the run controller accepting features and driving the BRAM
    modport slave (
        input  feat_in_valid,
        input  feat_in_data,
        output feat_in_ready,
        output feat_bram_ena,
        output feat_bram_addra,
        output feat_bram_din
    );
endinterface

`default_nettype wire

// File: rtl/gat_run_ctrl.sv
// ============================================================================
// Module      : gat_run_ctrl
// Description : GAT run sequencer: wait for loads, clear result BRAM, start
//               core, forward feature writes, flag layer completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gat_run_ctrl #(
    parameter int                    DATA_WIDTH         = 8,
    parameter int                    NUM_SUBGRAPHS      = 2708,
    parameter int                    NUM_FEATURE_OUT    = 16,
    parameter int                    NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int                    NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE        = '0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          gat_layer,
    input  wire logic          h_data_bram_load_done,
    input  wire logic          h_node_info_bram_load_done,
    input  wire logic          wgt_bram_load_done,
    output logic               gat_ready,
    output logic               core_start,
    output logic               core_layer,
    input  wire logic          subgraph_done,
    output logic               err,
    gat_run_ctrl_if.slave      feat_if
);

    localparam int CNT_W = $clog2(NEW_FEATURE_DEPTH + 1);
    localparam int SG_W  = $clog2(NUM_SUBGRAPHS + 1);

    localparam logic [CNT_W-1:0] c_DEPTH      = CNT_W'(NEW_FEATURE_DEPTH);
    localparam logic [CNT_W-1:0] c_LAST_ADDR  = CNT_W'(NEW_FEATURE_DEPTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);
    localparam logic [SG_W-1:0]  c_NUM_SG     = SG_W'(NUM_SUBGRAPHS);
    localparam logic [SG_W-1:0]  c_SG_ONE     = SG_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] w_wr_cnt_nxt;
    logic [SG_W-1:0]  r_sg_cnt;
    logic [SG_W-1:0]  w_sg_cnt_nxt;
    logic             r_layer;
    logic             r_err;
    logic             w_err_set;
    logic             w_all_loaded;
    logic             w_room;

    assign w_all_loaded = h_data_bram_load_done & h_node_info_bram_load_done
                        & wgt_bram_load_done;
    assign w_room       = (r_wr_cnt < c_DEPTH);
    assign core_layer   = r_layer;
    assign err          = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_wr_cnt <= '0;
            r_sg_cnt <= '0;
            r_layer  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
            r_sg_cnt <= w_sg_cnt_nxt;
            if (core_start) begin
                r_layer <= gat_layer;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt             = r_state;
        w_wr_cnt_nxt            = r_wr_cnt;
        w_sg_cnt_nxt            = r_sg_cnt;
        w_err_set               = 1'b0;
        gat_ready               = 1'b0;
        core_start              = 1'b0;
        feat_if.feat_in_ready   = 1'b0;
        feat_if.feat_bram_ena   = 1'b0;
        feat_if.feat_bram_addra = '0;
        feat_if.feat_bram_din   = '0;

        case (r_state)
            S_IDLE: begin
                if (w_all_loaded) begin
                    w_state_nxt  = S_CLEAR;
                    w_wr_cnt_nxt = '0;
                    w_sg_cnt_nxt = '0;
                end
            end

            S_CLEAR: begin
                feat_if.feat_bram_ena   = 1'b1;
                feat_if.feat_bram_addra = r_wr_cnt[NEW_FEATURE_ADDR_W-1:0];
                feat_if.feat_bram_din   = CLEAR_VALUE;
                w_wr_cnt_nxt            = r_wr_cnt + c_CNT_ONE;
                if (!w_all_loaded) begin
                    w_state_nxt = S_IDLE;
                    w_err_set   = 1'b1;
                end else if (r_wr_cnt == c_LAST_ADDR) begin
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                core_start   = 1'b1;
                w_wr_cnt_nxt = '0;
                if (!w_all_loaded) begin
                    w_state_nxt = S_IDLE;
                    w_err_set   = 1'b1;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                feat_if.feat_in_ready = w_room;
                if (feat_if.feat_in_valid) begin
                    if (w_room) begin
                        // zero-latency pass-through of the core write
                        feat_if.feat_bram_ena   = 1'b1;
                        feat_if.feat_bram_addra = r_wr_cnt[NEW_FEATURE_ADDR_W-1:0];
                        feat_if.feat_bram_din   = feat_if.feat_in_data;
                        w_wr_cnt_nxt            = r_wr_cnt + c_CNT_ONE;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                if (subgraph_done) begin
                    if (r_sg_cnt < c_NUM_SG) begin
                        w_sg_cnt_nxt = r_sg_cnt + c_SG_ONE;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                if (!w_all_loaded) begin
                    w_state_nxt = S_IDLE;
                    w_err_set   = 1'b1;
                end else if ((r_wr_cnt == c_DEPTH) && (r_sg_cnt == c_NUM_SG)) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                gat_ready = 1'b1;
                if (!w_all_loaded) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_gat_run_ctrl.sv
// ============================================================================
// Module      : tb_gat_run_ctrl
// Description : Directed self-checking bench for gat_run_ctrl (depth 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gat_run_ctrl;

    localparam int         DW    = 8;
    localparam int         NSG   = 4;
    localparam int         NFO   = 2;
    localparam int         DEPTH = NSG * NFO;
    localparam int         AW    = 3;
    localparam logic [7:0] CLR   = 8'h5A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic gat_layer = 1'b0;
    logic h_done = 1'b0;
    logic n_done = 1'b0;
    logic w_done = 1'b0;
    logic sg_done = 1'b0;
    logic gat_ready, core_start, core_layer, err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [DEPTH];
    logic [16:0] outs;

    gat_run_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) fif ();

    gat_run_ctrl #(
        .DATA_WIDTH         (DW),
        .NUM_SUBGRAPHS      (NSG),
        .NUM_FEATURE_OUT    (NFO),
        .NEW_FEATURE_DEPTH  (DEPTH),
        .NEW_FEATURE_ADDR_W (AW),
        .CLEAR_VALUE        (CLR)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .gat_layer                  (gat_layer),
        .h_data_bram_load_done      (h_done),
        .h_node_info_bram_load_done (n_done),
        .wgt_bram_load_done         (w_done),
        .gat_ready                  (gat_ready),
        .core_start                 (core_start),
        .core_layer                 (core_layer),
        .subgraph_done              (sg_done),
        .err                        (err),
        .feat_if                    (fif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fif.feat_bram_ena) mem[fif.feat_bram_addra] <= fif.feat_bram_din;
    end

    assign outs = {gat_ready, core_start, core_layer, fif.feat_in_ready,
                   fif.feat_bram_ena, fif.feat_bram_addra, fif.feat_bram_din, err};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        fif.feat_in_valid = 1'b0;
        fif.feat_in_data  = '0;
        sg_done = 1'b0;
        h_done  = 1'b0;
        n_done  = 1'b0;
        w_done  = 1'b0;
        rst     = 1'b1;
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
        #1;
    endtask

    // raise all load flags, wait out CLEAR and START, return in the first RUN cycle
    task automatic bring_up;
        bit seen;
        seen   = 1'b0;
        h_done = 1'b1;
        n_done = 1'b1;
        w_done = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (core_start === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bring_up_timeout core_start=%b required=1", core_start);
        end
        step();
    endtask

    task automatic test_reset;
        logic [2:0] ka;
        do_reset(2);
        checks++;
        if (outs !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0", outs);
        end
        h_done = 1'b1;
        step();
        n_done = 1'b1;
        #1;
        checks++;
        if (fif.feat_bram_ena !== 1'b0) begin
            errors++;
            $display("FAIL idle_partial_load ena=%b required=0", fif.feat_bram_ena);
        end
        step();
        w_done    = 1'b1;
        gat_layer = 1'b1;
        #1;
        checks++;
        if (fif.feat_bram_ena !== 1'b0) begin
            errors++;
            $display("FAIL idle_last_flag_cycle ena=%b required=0", fif.feat_bram_ena);
        end
        step();
        for (int k = 0; k < DEPTH; k++) begin
            ka = k[2:0];
            checks++;
            if ({fif.feat_bram_ena, fif.feat_bram_addra, fif.feat_bram_din, core_start}
                !== {1'b1, ka, CLR, 1'b0}) begin
                errors++;
                $display("FAIL clear_write k=%0d ena=%b addr=%0d din=%h start=%b required=1/%0d/5a/0",
                         k, fif.feat_bram_ena, fif.feat_bram_addra, fif.feat_bram_din, core_start, k);
            end
            step();
        end
        checks++;
        if ({core_start, fif.feat_bram_ena} !== 2'b10) begin
            errors++;
            $display("FAIL start_pulse start=%b ena=%b required=1/0", core_start, fif.feat_bram_ena);
        end
        step();
        checks++;
        if ({core_start, fif.feat_in_ready, core_layer} !== 3'b011) begin
            errors++;
            $display("FAIL run_entry start=%b ready=%b layer=%b required=0/1/1",
                     core_start, fif.feat_in_ready, core_layer);
        end
    endtask

    task automatic test_normal_run;
        int  k;
        int  sent;
        bit  v;
        bit  seen;
        logic [2:0] ka;
        do_reset(1);
        bring_up();
        k    = 0;
        sent = 0;
        for (int c = 0; c < 64 && k < DEPTH; c++) begin
            v = (c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            fif.feat_in_valid = v;
            fif.feat_in_data  = 8'h10 + 8'(k);
            sg_done = (!v && sent < NSG);
            ka = k[2:0];
            #1;
            if (v) begin
                checks++;
                if ({fif.feat_in_ready, fif.feat_bram_ena, fif.feat_bram_addra, fif.feat_bram_din}
                    !== {1'b1, 1'b1, ka, 8'h10 + 8'(k)}) begin
                    errors++;
                    $display("FAIL run_write k=%0d ready=%b ena=%b addr=%0d din=%h",
                             k, fif.feat_in_ready, fif.feat_bram_ena, fif.feat_bram_addra, fif.feat_bram_din);
                end
            end
            step();
            if (v) k++;
            if (sg_done) sent++;
        end
        fif.feat_in_valid = 1'b0;
        sg_done = 1'b0;
        while (sent < NSG) begin
            sg_done = 1'b1;
            step();
            sent++;
        end
        sg_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (gat_ready === 1'b1) seen = 1'b1;
        end
        checks++;
        if ({gat_ready, err, fif.feat_in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL run_done ready_out=%b err=%b in_ready=%b required=1/0/0",
                     gat_ready, err, fif.feat_in_ready);
        end
        for (int a = 0; a < DEPTH; a++) begin
            checks++;
            if (mem[a] !== 8'h10 + 8'(a)) begin
                errors++;
                $display("FAIL run_bram addr=%0d got=%h required=%h", a, mem[a], 8'h10 + 8'(a));
            end
        end
    endtask

    task automatic test_collision_and_done_idle;
        do_reset(1);
        bring_up();
        for (int k = 0; k < DEPTH; k++) begin
            fif.feat_in_valid = 1'b1;
            fif.feat_in_data  = 8'h40 + 8'(k);
            sg_done = (k % 2 == 1);
            step();
        end
        fif.feat_in_valid = 1'b0;
        sg_done = 1'b0;
        #1;
        checks++;
        if (gat_ready !== 1'b0) begin
            errors++;
            $display("FAIL collision_early gat_ready=%b required=0", gat_ready);
        end
        step();
        checks++;
        if ({gat_ready, err} !== 2'b10) begin
            errors++;
            $display("FAIL collision_ready gat_ready=%b err=%b required=1/0", gat_ready, err);
        end
        checks++;
        if (mem[7] !== 8'h47) begin
            errors++;
            $display("FAIL collision_last_word got=%h required=47", mem[7]);
        end
        h_done = 1'b0;
        #1;
        checks++;
        if (gat_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_hold gat_ready=%b required=1", gat_ready);
        end
        step();
        checks++;
        if ({gat_ready, err} !== 2'b00) begin
            errors++;
            $display("FAIL done_to_idle gat_ready=%b err=%b required=0/0", gat_ready, err);
        end
    endtask

    task automatic test_overflow;
        do_reset(1);
        bring_up();
        for (int k = 0; k < DEPTH; k++) begin
            fif.feat_in_valid = 1'b1;
            fif.feat_in_data  = 8'h20 + 8'(k);
            sg_done = (k % 2 == 1);
            step();
        end
        fif.feat_in_valid = 1'b1;
        fif.feat_in_data  = 8'hEE;
        sg_done = 1'b1;
        #1;
        checks++;
        if ({fif.feat_in_ready, fif.feat_bram_ena, err} !== 3'b000) begin
            errors++;
            $display("FAIL overflow_blocked ready=%b ena=%b err=%b required=0/0/0",
                     fif.feat_in_ready, fif.feat_bram_ena, err);
        end
        step();
        fif.feat_in_valid = 1'b0;
        sg_done = 1'b0;
        #1;
        checks++;
        if ({err, gat_ready} !== 2'b11) begin
            errors++;
            $display("FAIL overflow_err err=%b gat_ready=%b required=1/1", err, gat_ready);
        end
        checks++;
        if (mem[0] !== 8'h20) begin
            errors++;
            $display("FAIL overflow_addr0 got=%h required=20", mem[0]);
        end
    endtask

    task automatic test_abort_and_mid_clear_reset;
        logic [2:0] ka;
        do_reset(1);
        bring_up();
        for (int k = 0; k < 3; k++) begin
            fif.feat_in_valid = 1'b1;
            fif.feat_in_data  = 8'h30 + 8'(k);
            step();
        end
        fif.feat_in_valid = 1'b0;
        w_done = 1'b0;
        step();
        checks++;
        if ({err, fif.feat_in_ready, fif.feat_bram_ena, gat_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_idle err=%b ready=%b ena=%b gat_ready=%b required=1/0/0/0",
                     err, fif.feat_in_ready, fif.feat_bram_ena, gat_ready);
        end
        step();
        w_done = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            ka = k[2:0];
            checks++;
            if ({fif.feat_bram_ena, fif.feat_bram_addra, fif.feat_bram_din} !== {1'b1, ka, CLR}) begin
                errors++;
                $display("FAIL reclear k=%0d ena=%b addr=%0d din=%h required=1/%0d/5a",
                         k, fif.feat_bram_ena, fif.feat_bram_addra, fif.feat_bram_din, k);
            end
            if (k < 4) step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (outs !== 17'd0) begin
            errors++;
            $display("FAIL mid_clear_reset got=%h required=0", outs);
        end
        step();
        checks++;
        if ({fif.feat_bram_ena, fif.feat_bram_addra} !== 4'b1000) begin
            errors++;
            $display("FAIL post_reset_clear ena=%b addr=%0d required=1/0",
                     fif.feat_bram_ena, fif.feat_bram_addra);
        end
    endtask

    initial begin
        fif.feat_in_valid = 1'b0;
        fif.feat_in_data  = '0;
        test_reset();
        test_normal_run();
        test_collision_and_done_idle();
        test_overflow();
        test_abort_and_mid_clear_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/gat_run_ctrl.md
Name: gat_run_ctrl

Overview:
- Top-level run sequencer for the GAT accelerator.
- Waits for host BRAM loads (H data, node info, weights), clears the new-feature BRAM, then pulses the core start.
- Owns the new-feature BRAM write port during the run: forwards core feature writes with auto-incrementing address and counts completed subgraphs.
- Raises gat_ready when a full layer's features have been written.

Parameters:
DATA_WIDTH, 8, new-feature element width
NUM_SUBGRAPHS, 2708, subgraphs per layer
NUM_FEATURE_OUT, 16, output features per subgraph
NEW_FEATURE_DEPTH, NUM_SUBGRAPHS*NUM_FEATURE_OUT, new-feature BRAM words
NEW_FEATURE_ADDR_W, $clog2(NEW_FEATURE_DEPTH), BRAM address width
CLEAR_VALUE, 0, word written to every address during clear

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
gat_layer  in  1  layer select from register bank
h_data_bram_load_done  in  1  host load-done flag (level)
h_node_info_bram_load_done  in  1  host load-done flag (level)
wgt_bram_load_done  in  1  host load-done flag (level)
gat_ready  out  1  layer result available
core_start  out  1  one-cycle start pulse to GAT core
core_layer  out  1  layer latched at start
subgraph_done  in  1  core pulse, one per finished subgraph
feat_in_valid  in  1  core feature write request
feat_in_data  in  DATA_WIDTH  core feature value
feat_in_ready  out  1  write accepted this cycle
feat_bram_ena  out  1  new-feature BRAM port-A enable (also the write enable)
feat_bram_addra  out  NEW_FEATURE_ADDR_W  port-A address
feat_bram_din  out  DATA_WIDTH  port-A data
err  out  1  sticky error: overflow write or load-done drop mid-run

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - Synchronous, clk edge with rst=1, effective from any state (including mid-CLEAR or mid-RUN).
  - State goes to IDLE; counters go to 0.
  - All outputs go to 0: gat_ready, core_start, core_layer, feat_in_ready, feat_bram_ena, feat_bram_addra, feat_bram_din, err.
- all_loaded = AND of the three load_done flags.
- IDLE:
  - All outputs 0 except err, which holds.
  - Go to CLEAR when all_loaded=1. Clear addr counter, write counter and subgraph counter.
- CLEAR:
  - One write per cycle: feat_bram_ena=1, feat_bram_din=CLEAR_VALUE, addra=0..NEW_FEATURE_DEPTH-1.
  - After writing the last address, go to START.
  - Takes exactly NEW_FEATURE_DEPTH cycles.
- START:
  - core_start=1 for exactly one cycle; latch core_layer<=gat_layer.
  - Reset addr counter; next state RUN.
- RUN:
  - feat_in_ready=1 while write count < NEW_FEATURE_DEPTH.
  - Handshake: on feat_in_valid & feat_in_ready, feat_bram_ena=1 combinationally, addra=current count, din=feat_in_data; count increments next cycle.
  - Writes are zero-latency pass-through to the BRAM port.
  - Overflow: feat_in_valid=1 when count==NEW_FEATURE_DEPTH → no write, feat_in_ready=0, err<=1.
  - subgraph_done increments the subgraph counter, saturating at NUM_SUBGRAPHS. An extra pulse sets err.
  - Go to DONE when write count==NEW_FEATURE_DEPTH and subgraph count==NUM_SUBGRAPHS. This includes the cycle where the final write and final subgraph_done arrive together; both are counted and the transition occurs one cycle later.
- DONE:
  - gat_ready=1; no BRAM writes; feat_in_ready=0.
  - Stays until all_loaded falls, then goes to IDLE (gat_ready drops the next cycle).
- Abort: all_loaded falling during CLEAR, START or RUN → IDLE next cycle, err<=1, partial results abandoned.
- err clears only on rst.
- Counter widths: write/addr counter $clog2(NEW_FEATURE_DEPTH+1); subgraph counter $clog2(NUM_SUBGRAPHS+1). feat_bram_addra is the low NEW_FEATURE_ADDR_W bits.
- core_start never asserts outside START. Inputs in states other than RUN are ignored (no err) except as noted above.

Test Plan (NUM_SUBGRAPHS=4, NUM_FEATURE_OUT=2, depth 8, CLEAR_VALUE=0x5A):
1. Reset sequencing: rst=1 for 2 cycles, then raise the three load_done flags in different cycles → CLEAR starts only on the cycle after the last one rises. Then 8 consecutive writes of 0x5A to addrs 0..7, then core_start pulses once, then feat_in_ready=1.
2. Normal run: 8 writes 0x10..0x17 with valid toggled randomly, plus 4 subgraph_done pulses → BRAM addr k holds 0x10+k, gat_ready=1, err=0.
3. Final-write collision: last write and 4th subgraph_done in the same cycle → gat_ready rises exactly 2 cycles later.
4. Overflow: a 9th valid write and a 5th subgraph_done before DONE → addr 0 not overwritten, feat_in_ready=0, err=1.
5. Abort: wgt_bram_load_done dropped during RUN after 3 writes → IDLE, err=1. Reloading restarts CLEAR from addr 0.
6. Reset mid-CLEAR: rst asserted at clear addr 4 → all outputs 0 next cycle. Done-to-idle: in DONE, drop h_data_bram_load_done → gat_ready falls the next cycle.
